// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane alignment, misalignment traps and a
// three-state request handshake (idle, busy, done) with the data memory.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid_mem,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_read,
    output logic        o_dmem_write,
    output logic [3:0]  o_dmem_wmask,
    output logic [31:0] o_dmem_wdata,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_resp,
    output logic        o_stall_mem,
    output logic [31:0] o_load_result,
    output logic [3:0]  o_mem_rmask,
    output logic        o_trap_mem
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      r_state;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_load_result;

    logic [1:0]  w_off;
    logic [4:0]  w_shift;
    logic [3:0]  w_ld_mask;
    logic [3:0]  w_st_mask;
    logic        w_ld_bad;
    logic        w_st_bad;
    logic        w_trap;
    logic        w_access;
    logic [31:0] w_rshifted;
    logic [31:0] w_load_ext;

    assign w_off   = i_addr[1:0];
    assign w_shift = {w_off, 3'b000};

    always_comb begin
        w_ld_mask = 4'b0000;
        w_ld_bad  = 1'b0;
        case (i_funct3)
            3'b000, 3'b100: w_ld_mask = 4'b0001 << w_off;
            3'b001, 3'b101: begin
                w_ld_mask = 4'b0011 << w_off;
                w_ld_bad  = w_off[0];
            end
            3'b010: begin
                w_ld_mask = 4'b1111;
                w_ld_bad  = (w_off != 2'b00);
            end
            default: w_ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_st_mask = 4'b0000;
        w_st_bad  = 1'b0;
        case (i_funct3)
            3'b000: w_st_mask = 4'b0001 << w_off;
            3'b001: begin
                w_st_mask = 4'b0011 << w_off;
                w_st_bad  = w_off[0];
            end
            3'b010: begin
                w_st_mask = 4'b1111;
                w_st_bad  = (w_off != 2'b00);
            end
            default: w_st_bad = 1'b1;
        endcase
    end

    assign w_trap   = i_valid_mem & ((i_is_load & w_ld_bad) | (i_is_store & w_st_bad));
    assign w_access = i_valid_mem & (i_is_load | i_is_store) & ~w_trap;

    // funct3 is still valid here because the stall holds EX/MEM during BUSY
    assign w_rshifted = i_dmem_rdata >> w_shift;
    always_comb begin
        w_load_ext = 32'h0;
        case (i_funct3)
            3'b000:  w_load_ext = {{24{w_rshifted[7]}}, w_rshifted[7:0]};
            3'b001:  w_load_ext = {{16{w_rshifted[15]}}, w_rshifted[15:0]};
            3'b010:  w_load_ext = w_rshifted;
            3'b100:  w_load_ext = {24'h0, w_rshifted[7:0]};
            3'b101:  w_load_ext = {16'h0, w_rshifted[15:0]};
            default: w_load_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_load_result <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_load_result <= 32'h0;
                    if (w_access) begin
                        r_state <= StBusy;
                        r_read  <= i_is_load;
                        r_write <= i_is_store;
                    end
                end
                StBusy: begin
                    if (i_dmem_resp) begin
                        r_state       <= StDone;
                        r_read        <= 1'b0;
                        r_write       <= 1'b0;
                        r_load_result <= i_is_load ? w_load_ext : 32'h0;
                    end
                end
                StDone: begin
                    r_state       <= StIdle;
                    r_load_result <= 32'h0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs are forced low for the whole reset cycle, not just after the edge
    assign o_dmem_read   = r_read & ~rst;
    assign o_dmem_write  = r_write & ~rst;
    assign o_load_result = rst ? 32'h0 : r_load_result;
    assign o_stall_mem   = ~rst & (((r_state == StIdle) & w_access) | (r_state == StBusy));

    assign o_dmem_addr  = {i_addr[31:2], 2'b00};
    assign o_dmem_wmask = i_is_store ? w_st_mask : 4'b0000;
    assign o_dmem_wdata = i_store_data << w_shift;
    assign o_mem_rmask  = i_is_load ? w_ld_mask : 4'b0000;
    assign o_trap_mem   = w_trap;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// load/store/other traffic scored against a byte-level arithmetic model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem, is_load, is_store, dmem_resp;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, dmem_rdata;
    logic [31:0] dmem_addr, dmem_wdata, load_result;
    logic        dmem_read, dmem_write, stall_mem, trap_mem;
    logic [3:0]  dmem_wmask, mem_rmask;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid_mem  (valid_mem),
        .i_is_load    (is_load),
        .i_is_store   (is_store),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_store_data (store_data),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_read  (dmem_read),
        .o_dmem_write (dmem_write),
        .o_dmem_wmask (dmem_wmask),
        .o_dmem_wdata (dmem_wdata),
        .i_dmem_rdata (dmem_rdata),
        .i_dmem_resp  (dmem_resp),
        .o_stall_mem  (stall_mem),
        .o_load_result(load_result),
        .o_mem_rmask  (mem_rmask),
        .o_trap_mem   (trap_mem)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: sizes in bytes, alignment by modulo, lane extraction by shifting.
    function automatic void model(input logic v, input logic ld, input logic st,
                                  input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rd,
                                  output logic [3:0] e_wm, output logic [3:0] e_rm,
                                  output logic [31:0] e_wd, output logic [31:0] e_lr,
                                  output logic e_trap, output logic e_acc);
        int unsigned off, size;
        bit ld_ok, st_ok, mis;
        logic [3:0] mask;
        longint unsigned raw;
        off   = a % 4;
        size  = 1 << f3[1:0];
        ld_ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        st_ok = (f3 < 3);
        mis   = (a % size) != 0;
        if (size == 4) mask = 4'hF;
        else if (size < 4) mask = 4'(((1 << size) - 1) << off);
        else mask = 4'h0;
        e_rm   = (ld && ld_ok) ? mask : 4'h0;
        e_wm   = (st && st_ok) ? mask : 4'h0;
        e_wd   = sd << (8 * off);
        e_trap = v && ((ld && (!ld_ok || mis)) || (st && (!st_ok || mis)));
        e_acc  = v && (ld || st) && !e_trap;
        raw = 0;
        if (size <= 4) begin
            raw = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
            if (f3[2] == 1'b0 && size < 4 && ((raw >> (8 * size - 1)) & 1) == 1)
                raw = raw - (64'd1 << (8 * size));
        end
        e_lr = ld ? 32'(raw) : 32'h0;
    endfunction

    // Presents one instruction in IDLE; for an access, holds it through nb BUSY
    // cycles (response in the last) and the DONE cycle.
    task automatic run_txn(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                           input int nb);
        logic [3:0]  e_wm, e_rm;
        logic [31:0] e_wd, e_lr;
        logic        e_trap, e_acc;
        model(v, ld, st, f3, a, sd, rd, e_wm, e_rm, e_wd, e_lr, e_trap, e_acc);
        valid_mem = v; is_load = ld; is_store = st; funct3 = f3;
        addr = a; store_data = sd; dmem_rdata = rd;
        dmem_resp = e_acc ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
        check_eq("wmask", 32'(dmem_wmask), 32'(e_wm));
        check_eq("wdata", dmem_wdata, e_wd);
        check_eq("rmask", 32'(mem_rmask), 32'(e_rm));
        check_eq("trap", 32'(trap_mem), 32'(e_trap));
        check_eq("idle_stall", 32'(stall_mem), 32'(e_acc));
        check_eq("idle_read", 32'(dmem_read), 32'h0);
        check_eq("idle_write", 32'(dmem_write), 32'h0);
        check_eq("idle_lres", load_result, 32'h0);
        step();
        if (!e_acc) begin
            dmem_resp = 1'b0;
            return;
        end
        for (int k = 1; k <= nb; k++) begin
            dmem_resp = (k == nb);
            @(negedge clk);
            check_eq("busy_stall", 32'(stall_mem), 32'h1);
            check_eq("busy_read", 32'(dmem_read), 32'(ld));
            check_eq("busy_write", 32'(dmem_write), 32'(st));
            check_eq("busy_lres", load_result, 32'h0);
            step();
        end
        dmem_resp  = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom();
        @(negedge clk);
        check_eq("done_stall", 32'(stall_mem), 32'h0);
        check_eq("done_read", 32'(dmem_read), 32'h0);
        check_eq("done_write", 32'(dmem_write), 32'h0);
        check_eq("done_lres", load_result, e_lr);
        step();
        dmem_resp = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_mem = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h0; store_data = 32'h0; dmem_rdata = 32'h0; dmem_resp = 1'b0;
        step(); step();
        @(negedge clk);
        check_eq("rst_stall", 32'(stall_mem), 32'h0);
        check_eq("rst_read", 32'(dmem_read), 32'h0);
        check_eq("rst_write", 32'(dmem_write), 32'h0);
        check_eq("rst_lres", load_result, 32'h0);
        step();
        rst = 1'b0; valid_mem = 1'b0;
        step();

        run_txn(1, 1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF00, 1);  // lb sign-extend
        run_txn(1, 0, 1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 3);  // sh, slow resp
        run_txn(1, 1, 0, 3'b010, 32'h3001, 32'h0, 32'h1234_5678, 1);  // lw misaligned
        run_txn(1, 1, 0, 3'b101, 32'h4002, 32'h0, 32'h9876_0000, 1);  // lhu upper half
        run_txn(1, 1, 0, 3'b010, 32'h10, 32'h0, 32'hCAFE_F00D, 1);    // back-to-back
        run_txn(1, 0, 1, 3'b010, 32'h14, 32'hDEAD_BEEF, 32'h0, 1);
        run_txn(1, 0, 0, 3'b010, 32'h18, 32'h0, 32'h0, 1);            // non-memory op

        // Reset in the second BUSY cycle abandons the access.
        valid_mem = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h20; dmem_rdata = 32'h5555_AAAA; dmem_resp = 1'b0;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstbusy_read", 32'(dmem_read), 32'h0);
        check_eq("rstbusy_stall", 32'(stall_mem), 32'h0);
        step();
        rst = 1'b0; valid_mem = 1'b0; dmem_resp = 1'b1;
        @(negedge clk);
        check_eq("post_rst_stall", 32'(stall_mem), 32'h0);
        check_eq("post_rst_lres", load_result, 32'h0);
        step();
        dmem_resp = 1'b0;
        @(negedge clk);
        check_eq("post_rst_lres2", load_result, 32'h0);
        check_eq("post_rst_read", 32'(dmem_read), 32'h0);
        step();

        for (int i = 0; i < 300; i++) begin
            logic v, ld, st;
            int unsigned kind;
            kind = $urandom_range(0, 4);
            v  = ($urandom_range(0, 7) != 0);
            ld = (kind < 2);
            st = (kind == 2 || kind == 3);
            run_txn(v, ld, st, 3'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom(),
                    int'($urandom_range(1, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
